inta_sequencer: RTL and testbench
=================================

Name: inta_sequencer

Overview:
- CPU-side initiator of the interrupt-acknowledge protocol for the 8259A-style priority resolver.
- Detects a raised INT and drives the two active-low INTA pulses the resolver counts.
- Captures the vector byte presented on the data bus during the second pulse.
- Hands that vector to the CPU core over a valid/ack handshake. Sits between the PIC and the CPU core model.

Parameters:
PULSE_W, 3, INTA low time per pulse in clk cycles (1..255)
GAP_W, 2, INTA high time between the two pulses in clk cycles (1..255)

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-high reset
INT  in  1  interrupt request from PIC, asynchronous to clk
int_enable  in  1  CPU interrupt-enable flag; sequence starts only when 1
D  in  8  data bus from PIC; vector byte valid during second INTA pulse
INTA  out  1  interrupt acknowledge to PIC, active low, idle high, registered
vec_valid  out  1  captured vector available to CPU core
vector  out  8  captured vector byte
vec_ack  in  1  CPU core consumed vector
busy  out  1  high in any state other than IDLE
spurious  out  1  INT was low at the start of pulse 2; valid with vec_valid

Behaviour:
- Reset (async, immediate):
  - INTA=1, vec_valid=0, vector=8'h00, spurious=0, busy=0, state=IDLE, counter=0.
  - Reset mid-pulse truncates INTA; the PIC may have counted a falling edge. This is accepted; software re-initialises the PIC after reset.
- Synchronisation: INT passes through a 2-flop synchroniser (int_s). All decisions use int_s, never raw INT.
- States: IDLE, ACK1_LOW, ACK1_GAP, ACK2_LOW, DONE.
- IDLE:
  - if int_s=1 and int_enable=1, go to ACK1_LOW and load counter=PULSE_W-1. INTA is driven 0 from that edge.
  - otherwise stay; INTA=1.
- ACK1_LOW:
  - INTA=0; counter decrements each cycle.
  - at counter=0, go to ACK1_GAP and load counter=GAP_W-1.
- ACK1_GAP:
  - INTA=1.
  - at counter=0, sample int_s into spurious_pending (1 if int_s=0), go to ACK2_LOW and load counter=PULSE_W-1.
- ACK2_LOW:
  - INTA=0.
  - on the counter=0 cycle, register vector<=D and spurious<=spurious_pending, then go to DONE. INTA returns to 1 on that same edge.
- DONE:
  - INTA=1, vec_valid=1; vector and spurious held stable.
  - on vec_ack=1, go to IDLE next edge and clear vec_valid.
  - vec_ack outside DONE is ignored.
- Every pulse is exactly PULSE_W cycles low and the gap exactly GAP_W cycles high.
- int_enable and INT are ignored once the sequence has left IDLE. The sequence always completes both pulses (the PIC pulse counter must never be left at 1).
- Re-arm: from IDLE after DONE, a new sequence needs int_s=1 again. If INT is still high, a new sequence starts the cycle after returning to IDLE. Minimum INTA high time between sequences is therefore 2 cycles (DONE with ack, IDLE).
- Latency: INT rising (setup met) at edge 0 → int_s=1 after edge 2 → INTA falls at edge 3. Total INTA activity is 2*PULSE_W+GAP_W cycles. vec_valid rises the edge after pulse 2 ends.
- Counter is 8 bits. PULSE_W or GAP_W = 0 is illegal; behaviour is undefined and flagged by an assertion in simulation.

Test Plan:
- Default params, int_enable=1, INT raised at cycle 10 and held, D=8'h4B during pulse 2 → INTA low cycles 13-15, high 16-17, low 18-20; vec_valid=1 from cycle 21, vector=8'h4B, spurious=0, busy=1 from cycle 13 until the cycle after vec_ack.
- int_enable=0 with INT high for 50 cycles → INTA stays 1, busy=0. Raise int_enable → INTA falls 1 cycle later.
- INT dropped during ACK1_LOW → both pulses still issued; spurious=1 with vec_valid; vector=D sampled in pulse 2.
- vec_ack withheld 20 cycles while INT stays high → INTA held 1, vector stable. Assert vec_ack → new sequence's INTA falls 2 cycles later.
- reset pulsed during ACK1_GAP → INTA=1, vec_valid=0, vector=8'h00 immediately. With INT high after release, a clean sequence begins 3 edges later.
- PULSE_W=1, GAP_W=1 → INTA pattern 0,1,0 over consecutive cycles; vector captured from D in the single pulse-2 cycle.

Source files
------------

// File: rtl/inta_sequencer_if.sv
// Signal bundle between the INTA sequencer, the 8259A-style PIC and the CPU core.
// The master side is the sequencer; the slave side is the PIC/CPU environment.
interface inta_sequencer_if;
   logic       INT;
   logic       int_enable;
   logic [7:0] D;
   logic       INTA;
   logic       vec_valid;
   logic [7:0] vector;
   logic       vec_ack;
   logic       busy;
   logic       spurious;

   modport master (
      input  INT, int_enable, D, vec_ack,
      output INTA, vec_valid, vector, busy, spurious
   );

   modport slave (
      output INT, int_enable, D, vec_ack,
      input  INTA, vec_valid, vector, busy, spurious
   );
endinterface

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge initiator: issues two active-low INTA pulses to the PIC,
// captures the vector byte in pulse 2 and offers it to the CPU via valid/ack.
module inta_sequencer #(
   parameter int PULSE_W = 3,
   parameter int GAP_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   inta_sequencer_if.master  bus
);
   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_W - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(GAP_W - 1);

   typedef enum logic [2:0] {IDLE, ACK1_LOW, ACK1_GAP, ACK2_LOW, DONE} state_t;

   state_t     state_reg, state_next;
   logic [7:0] count_reg, count_next;
   logic [1:0] int_sync_reg;
   logic       int_s;
   logic       inta_reg, inta_next;
   logic [7:0] vector_reg, vector_next;
   logic       spurious_reg, spurious_next;
   logic       pending_reg, pending_next;

   assign int_s = int_sync_reg[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         int_sync_reg <= '0;
         inta_reg     <= 1'b1;
         vector_reg   <= '0;
         spurious_reg <= 1'b0;
         pending_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         int_sync_reg <= {int_sync_reg[0], bus.INT};
         inta_reg     <= inta_next;
         vector_reg   <= vector_next;
         spurious_reg <= spurious_next;
         pending_reg  <= pending_next;
      end
   end

   // Once out of IDLE the sequence runs to DONE regardless of INT/int_enable,
   // so the PIC never sees a lone first pulse.
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      vector_next   = vector_reg;
      spurious_next = spurious_reg;
      pending_next  = pending_reg;
      case (state_reg)
         IDLE: begin
            if (int_s && bus.int_enable) begin
               state_next = ACK1_LOW;
               count_next = PULSE_LOAD;
            end
         end
         ACK1_LOW: begin
            if (count_reg == 8'd0) begin
               state_next = ACK1_GAP;
               count_next = GAP_LOAD;
            end else begin
               count_next = count_reg - 8'd1;
            end
         end
         ACK1_GAP: begin
            if (count_reg == 8'd0) begin
               pending_next = ~int_s;
               state_next   = ACK2_LOW;
               count_next   = PULSE_LOAD;
            end else begin
               count_next = count_reg - 8'd1;
            end
         end
         ACK2_LOW: begin
            if (count_reg == 8'd0) begin
               vector_next   = bus.D;
               spurious_next = pending_reg;
               state_next    = DONE;
            end else begin
               count_next = count_reg - 8'd1;
            end
         end
         DONE: begin
            if (bus.vec_ack) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // INTA is registered from the next state so it changes on the same edge as the state.
   always_comb begin
      inta_next = ~((state_next == ACK1_LOW) || (state_next == ACK2_LOW));
   end

   assign bus.INTA      = inta_reg;
   assign bus.vec_valid = (state_reg == DONE);
   assign bus.vector    = vector_reg;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.spurious  = spurious_reg;

   param_range_a: assert property (@(posedge clk)
      (PULSE_W >= 1) && (PULSE_W <= 255) && (GAP_W >= 1) && (GAP_W <= 255));
endmodule

// File: tb/tb_inta_sequencer.sv
// Directed and randomized checks of two sequencer instances (3/2 and 1/1 timing)
// against expected INTA waveforms and captured vectors derived from the pulse widths.
module tb_inta_sequencer;
   logic clk;
   logic reset;

   inta_sequencer_if ifa ();
   inta_sequencer_if ifb ();

   logic       int_v  [2];
   logic       en_v   [2];
   logic       ack_v  [2];
   logic [7:0] d_v    [2];
   logic       inta_o [2];
   logic       vv_o   [2];
   logic       busy_o [2];
   logic       spur_o [2];
   logic [7:0] vec_o  [2];

   int n_checks = 0;
   int n_errors = 0;

   assign ifa.INT = int_v[0];  assign ifa.int_enable = en_v[0];
   assign ifa.D   = d_v[0];    assign ifa.vec_ack    = ack_v[0];
   assign ifb.INT = int_v[1];  assign ifb.int_enable = en_v[1];
   assign ifb.D   = d_v[1];    assign ifb.vec_ack    = ack_v[1];

   assign inta_o[0] = ifa.INTA;  assign inta_o[1] = ifb.INTA;
   assign vv_o[0]   = ifa.vec_valid; assign vv_o[1] = ifb.vec_valid;
   assign busy_o[0] = ifa.busy;  assign busy_o[1] = ifb.busy;
   assign spur_o[0] = ifa.spurious; assign spur_o[1] = ifb.spurious;
   assign vec_o[0]  = ifa.vector; assign vec_o[1] = ifb.vector;

   inta_sequencer #(.PULSE_W(3), .GAP_W(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
   inta_sequencer #(.PULSE_W(1), .GAP_W(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Two cycles in which the synchroniser is still catching up with INT.
   task automatic idle2(input int sel);
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("idle_inta[%0d]", sel), 32'(inta_o[sel]), 32'd1);
         check($sformatf("idle_busy[%0d]", sel), 32'(busy_o[sel]), 32'd0);
      end
   endtask

   // Expected: PULSE_W low, GAP_W high, PULSE_W low, then DONE holding D of the last low cycle.
   task automatic do_pulses(input int sel, input bit drop, input bit rand_ctl, output logic [7:0] ev);
      int p, g, tot;
      p   = (sel == 0) ? 3 : 1;
      g   = (sel == 0) ? 2 : 1;
      tot = 2 * p + g;
      ev  = 8'h00;
      for (int k = 0; k < tot; k++) begin
         tick();
         check($sformatf("inta[%0d] k=%0d", sel, k), 32'(inta_o[sel]),
               (k < p || k >= p + g) ? 32'd0 : 32'd1);
         check($sformatf("busy_seq[%0d]", sel), 32'(busy_o[sel]), 32'd1);
         check($sformatf("vv_seq[%0d]", sel), 32'(vv_o[sel]), 32'd0);
         d_v[sel] = 8'($urandom);
         ev = d_v[sel];
         if (drop && k == 0) int_v[sel] = 1'b0;
         if (rand_ctl) begin
            en_v[sel]  = 1'($urandom);
            ack_v[sel] = 1'($urandom);
         end
      end
      tick();
      ack_v[sel] = 1'b0;
      en_v[sel]  = 1'b1;
      check($sformatf("vv_done[%0d]", sel), 32'(vv_o[sel]), 32'd1);
      check($sformatf("vector[%0d]", sel), 32'(vec_o[sel]), 32'(ev));
      check($sformatf("spurious[%0d]", sel), 32'(spur_o[sel]), 32'(drop));
      check($sformatf("inta_done[%0d]", sel), 32'(inta_o[sel]), 32'd1);
      check($sformatf("busy_done[%0d]", sel), 32'(busy_o[sel]), 32'd1);
   endtask

   task automatic do_ack(input int sel, input int delay, input logic [7:0] ev,
                         input bit spur, input bit lower);
      if (lower) int_v[sel] = 1'b0;
      for (int i = 0; i < delay; i++) begin
         d_v[sel] = 8'($urandom);
         tick();
         check($sformatf("hold_vv[%0d]", sel), 32'(vv_o[sel]), 32'd1);
         check($sformatf("hold_vec[%0d]", sel), 32'(vec_o[sel]), 32'(ev));
         check($sformatf("hold_spur[%0d]", sel), 32'(spur_o[sel]), 32'(spur));
         check($sformatf("hold_inta[%0d]", sel), 32'(inta_o[sel]), 32'd1);
      end
      ack_v[sel] = 1'b1;
      tick();
      ack_v[sel] = 1'b0;
      check($sformatf("ack_vv[%0d]", sel), 32'(vv_o[sel]), 32'd0);
      check($sformatf("ack_busy[%0d]", sel), 32'(busy_o[sel]), 32'd0);
      check($sformatf("ack_inta[%0d]", sel), 32'(inta_o[sel]), 32'd1);
      if (lower) begin
         tick();
         check($sformatf("rearm_inta[%0d]", sel), 32'(inta_o[sel]), 32'd1);
         check($sformatf("rearm_busy[%0d]", sel), 32'(busy_o[sel]), 32'd0);
      end
   endtask

   initial begin
      logic [7:0] ev;
      int sel;
      bit drop;

      reset = 1'b1;
      for (int s = 0; s < 2; s++) begin
         int_v[s] = 1'b0; en_v[s] = 1'b1; ack_v[s] = 1'b0; d_v[s] = 8'h00;
      end
      #1;
      for (int s = 0; s < 2; s++) begin
         check($sformatf("rst_inta[%0d]", s), 32'(inta_o[s]), 32'd1);
         check($sformatf("rst_vv[%0d]", s), 32'(vv_o[s]), 32'd0);
         check($sformatf("rst_vec[%0d]", s), 32'(vec_o[s]), 32'd0);
         check($sformatf("rst_busy[%0d]", s), 32'(busy_o[s]), 32'd0);
         check($sformatf("rst_spur[%0d]", s), 32'(spur_o[s]), 32'd0);
      end
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      $display("step: basic sequence then ack withheld 20 cycles with INT high");
      int_v[0] = 1'b1;
      idle2(0);
      do_pulses(0, 1'b0, 1'b0, ev);
      do_ack(0, 20, ev, 1'b0, 1'b0);
      do_pulses(0, 1'b0, 1'b0, ev);
      do_ack(0, 2, ev, 1'b0, 1'b1);

      $display("step: int_enable low for 50 cycles");
      en_v[0]  = 1'b0;
      int_v[0] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check("en0_inta", 32'(inta_o[0]), 32'd1);
         check("en0_busy", 32'(busy_o[0]), 32'd0);
      end
      en_v[0] = 1'b1;
      do_pulses(0, 1'b0, 1'b0, ev);
      do_ack(0, 3, ev, 1'b0, 1'b1);

      $display("step: INT dropped during first pulse");
      int_v[0] = 1'b1;
      idle2(0);
      do_pulses(0, 1'b1, 1'b0, ev);
      do_ack(0, 2, ev, 1'b1, 1'b1);

      $display("step: reset during gap");
      int_v[0] = 1'b1;
      idle2(0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("pre_rst_inta k=%0d", k), 32'(inta_o[0]), (k < 3) ? 32'd0 : 32'd1);
      end
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_inta", 32'(inta_o[0]), 32'd1);
      check("mid_rst_vv", 32'(vv_o[0]), 32'd0);
      check("mid_rst_vec", 32'(vec_o[0]), 32'd0);
      check("mid_rst_busy", 32'(busy_o[0]), 32'd0);
      tick();
      reset = 1'b0;
      idle2(0);
      do_pulses(0, 1'b0, 1'b0, ev);
      do_ack(0, 3, ev, 1'b0, 1'b1);

      $display("step: single-cycle pulses and gap");
      int_v[1] = 1'b1;
      idle2(1);
      do_pulses(1, 1'b0, 1'b0, ev);
      do_ack(1, 3, ev, 1'b0, 1'b0);
      do_pulses(1, 1'b0, 1'b0, ev);
      do_ack(1, 1, ev, 1'b0, 1'b1);

      for (int n = 0; n < 12; n++) begin
         sel  = int'($urandom_range(0, 1));
         drop = (sel == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         $display("step: random sequence %0d on dut %0d drop=%0d", n, sel, drop);
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            tick();
            check("rnd_idle_inta", 32'(inta_o[sel]), 32'd1);
         end
         int_v[sel] = 1'b1;
         idle2(sel);
         do_pulses(sel, drop, 1'b1, ev);
         do_ack(sel, int'($urandom_range(1, 6)), ev, drop, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
